// File: rtl/fp4_accumulator.sv
// FP4 product accumulator: decodes signed FP4 terms to half-units and sums them
// with saturation, handing each finished sum off through a valid/ready register.
module fp4_accumulator #(
  parameter int ACC_W   = 12,
  parameter int MAX_LEN = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_prod_valid,
  input  logic [3:0]       i_prod,
  input  logic             i_last,
  output logic             o_prod_ready,
  input  logic             i_clear,
  output logic [ACC_W-1:0] o_acc,
  output logic             o_acc_valid,
  input  logic             i_acc_ready,
  output logic [7:0]       o_acc_count,
  output logic             o_acc_sat
);

  typedef enum logic {ACCUM, HOLD} state_t;

  localparam logic signed [ACC_W-1:0] SMAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SMIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t                  state_q, state_d;
  logic signed [ACC_W-1:0] sum_q, sum_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    sat_q, sat_d;
  logic [ACC_W-1:0]        acc_d;
  logic [7:0]              acc_cnt_d;
  logic                    acc_sat_d, acc_vld_d;

  logic [3:0]              mag;
  logic signed [4:0]       mag_s, dec_val;
  logic signed [ACC_W-1:0] base_sum, add_sum;
  logic [7:0]              base_cnt, new_cnt;
  logic                    base_sat, ovf, done;
  logic signed [ACC_W:0]   wide;

  // magnitude in half-units: {exp,man} -> 0,1,2,3,4,6,8,12
  always_comb begin
    mag = 4'd0;
    case (i_prod[2:0])
      3'd0: mag = 4'd0;
      3'd1: mag = 4'd1;
      3'd2: mag = 4'd2;
      3'd3: mag = 4'd3;
      3'd4: mag = 4'd4;
      3'd5: mag = 4'd6;
      3'd6: mag = 4'd8;
      3'd7: mag = 4'd12;
      default: mag = 4'd0;
    endcase
  end

  assign mag_s   = {1'b0, mag};
  assign dec_val = i_prod[3] ? -mag_s : mag_s;

  // a clear alongside an accepted product restarts the sum from that product
  assign base_sum = i_clear ? '0 : sum_q;
  assign base_cnt = i_clear ? 8'd0 : cnt_q;
  assign base_sat = i_clear ? 1'b0 : sat_q;

  assign wide    = {base_sum[ACC_W-1], base_sum} + {{(ACC_W-4){dec_val[4]}}, dec_val};
  assign ovf     = wide[ACC_W] ^ wide[ACC_W-1];
  assign add_sum = ovf ? (wide[ACC_W] ? SMIN : SMAX) : wide[ACC_W-1:0];
  assign new_cnt = base_cnt + 8'd1;
  assign done    = i_last || (new_cnt == 8'(MAX_LEN));

  assign o_prod_ready = (state_q == ACCUM);

  always_comb begin
    state_d   = state_q;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    sat_d     = sat_q;
    acc_d     = o_acc;
    acc_cnt_d = o_acc_count;
    acc_sat_d = o_acc_sat;
    acc_vld_d = o_acc_valid;
    case (state_q)
      ACCUM: begin
        if (i_prod_valid) begin
          if (done) begin
            acc_d     = add_sum;
            acc_cnt_d = new_cnt;
            acc_sat_d = base_sat | ovf;
            acc_vld_d = 1'b1;
            sum_d     = '0;
            cnt_d     = 8'd0;
            sat_d     = 1'b0;
            state_d   = HOLD;
          end else begin
            sum_d = add_sum;
            cnt_d = new_cnt;
            sat_d = base_sat | ovf;
          end
        end else if (i_clear) begin
          sum_d = '0;
          cnt_d = 8'd0;
          sat_d = 1'b0;
        end
      end
      HOLD: begin
        if (i_acc_ready) begin
          acc_vld_d = 1'b0;
          state_d   = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ACCUM;
      sum_q       <= '0;
      cnt_q       <= 8'd0;
      sat_q       <= 1'b0;
      o_acc       <= '0;
      o_acc_count <= 8'd0;
      o_acc_sat   <= 1'b0;
      o_acc_valid <= 1'b0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      o_acc       <= acc_d;
      o_acc_count <= acc_cnt_d;
      o_acc_sat   <= acc_sat_d;
      o_acc_valid <= acc_vld_d;
    end
  end

endmodule

// File: doc/fp4_accumulator.md
FP4_ACCUMULATOR -- requirements
Module: fp4_accumulator

Interface
REQ-001 SHALL have parameter ACC_W, default 12: accumulator and result width, two's complement, 1 fractional bit (LSB = 0.5).
REQ-002 SHALL have parameter MAX_LEN, default 16: maximum products per result; legal range 2..255.
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port i_prod_valid, input, 1 bit: an FP4 product is presented.
REQ-006 SHALL have port i_prod, input, 4 bits: FP4 product {sign, exp[1:0], man}, exponent bias 1.
REQ-007 SHALL have port i_last, input, 1 bit: the presented product is the final term of the current sum.
REQ-008 SHALL have port o_prod_ready, output, 1 bit: a product is accepted on a cycle with i_prod_valid and o_prod_ready both high.
REQ-009 SHALL have port i_clear, input, 1 bit: synchronously discard the partial sum.
REQ-010 SHALL have port o_acc, output, ACC_W bits: completed signed sum.
REQ-011 SHALL have port o_acc_valid, output, 1 bit: o_acc, o_acc_count and o_acc_sat hold a completed result.
REQ-012 SHALL have port i_acc_ready, input, 1 bit: the consumer takes the result on a cycle with o_acc_valid and i_acc_ready both high.
REQ-013 SHALL have port o_acc_count, output, 8 bits: number of products summed into o_acc.
REQ-014 SHALL have port o_acc_sat, output, 1 bit: saturation occurred during this result.

Function
REQ-015 SHALL decode i_prod to half-units: magnitude codes 000..111 map to 0, 1, 2, 3, 4, 6, 8, 12.
REQ-016 SHALL negate the magnitude when the sign bit is set; codes 0000 and 1000 both decode to 0.
REQ-017 SHALL have two states, ACCUM and HOLD, and SHALL enter ACCUM on reset.
REQ-018 SHALL drive o_prod_ready high in ACCUM and low in HOLD.
REQ-019 SHALL, on each accepted product in ACCUM, add the decoded value to the partial sum with saturation to the ACC_W signed range and increment the partial count.
REQ-020 SHALL make saturation sticky: once any add clamps, the flag stays set until the result is produced or cleared.
REQ-021 SHALL complete a result when the accepted product has i_last=1 or brings the partial count to MAX_LEN, whichever comes first.
REQ-022 On completion, SHALL on the same edge:
- load o_acc with the final saturated sum, o_acc_count with the final count and o_acc_sat with the sticky flag;
- set o_acc_valid;
- zero the partial sum, partial count and sticky flag;
- enter HOLD.
REQ-023 Latency SHALL be 1 cycle: o_acc_valid rises on the edge that accepts the completing product.
REQ-024 In HOLD, o_acc_valid, o_acc, o_acc_count and o_acc_sat SHALL stay stable until the handshake completes.
REQ-025 On the handshake edge in HOLD, SHALL clear o_acc_valid and return to ACCUM; o_prod_ready is high from the following cycle.
REQ-026 i_clear in ACCUM SHALL zero the partial sum, count and sticky flag.
REQ-027 If i_clear coincides with an accepted product, SHALL start a fresh sum containing only that product (count 1); if that product also has i_last=1, SHALL complete immediately with that single value.
REQ-028 i_clear in HOLD SHALL NOT affect the pending result and SHALL NOT affect the (already zero) partial state.
REQ-029 SHALL ignore i_prod, i_last and i_clear when no product is accepted, except i_clear as given in REQ-026.
REQ-030 o_acc SHALL retain its last value after the handshake until the next completion.

Reset
REQ-031 While i_rst_n is low, SHALL asynchronously force:
- state ACCUM;
- partial sum, count and sticky flag to 0;
- o_acc, o_acc_count and o_acc_sat to 0;
- o_acc_valid to 0;
- o_prod_ready to 1.
REQ-032 Reset asserted mid-sum or in HOLD SHALL discard all partial and pending results with no output.
REQ-033 SHALL release from reset synchronously to i_clk, accepting products from the first edge after deassertion.

Verification
REQ-034 Products 0010, 0101, 1011, 0111 with i_last on the 4th, i_acc_ready=1 -> o_acc=17 (+8.5), o_acc_count=4, o_acc_sat=0, o_acc_valid high for 1 cycle after the 4th accept.
REQ-035 Send 16 × 0111 with no i_last (MAX_LEN=16) -> auto-complete with o_acc=192, o_acc_count=16; the 17th product is the first term of the next sum.
REQ-036 Hold i_acc_ready=0 for 5 cycles after completion while i_prod_valid=1 -> o_prod_ready=0, outputs stable; after the handshake, the next product is accepted one cycle later.
REQ-037 With ACC_W=6, send 6 × 0111 then i_last -> o_acc=31 and o_acc_sat=1; the next result reports o_acc_sat=0.
REQ-038 Send 0111, 0111, then 0010 with i_clear and i_last -> o_acc=2, o_acc_count=1; 1000 as a single last product -> o_acc=0.
REQ-039 Assert i_rst_n low mid-sum and again while in HOLD -> o_acc_valid=0, o_acc=0, o_prod_ready=1 immediately, with no spurious result after release.
